hex_segment_fx: RTL and testbench

//  Output stage between a 7-segment PIO out_port (active-low, 7'h7F = all off) and the HEX pins.

---
 rtl/hex_segment_fx_pkg.sv | 25 ++
 rtl/hex_segment_fx_if.sv | 11 +
 rtl/hex_segment_fx_timer.sv | 59 +++++
 rtl/hex_segment_fx.sv | 94 +++++++++
 tb/tb_hex_segment_fx.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/hex_segment_fx_pkg.sv
// Shared register map, CTRL bit positions and segment constants for the
// hex_segment_fx output stage.
package hex_fx_pkg;

  typedef enum logic [1:0] {
    REG_CTRL      = 2'd0,
    REG_BLINK_DIV = 2'd1,
    REG_BRIGHT    = 2'd2,
    REG_STATUS    = 2'd3
  } reg_addr_e;

  localparam int CTRL_BLINK = 0;
  localparam int CTRL_LAMP  = 1;
  localparam int CTRL_BLANK = 2;

  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam logic [6:0] SEG_ALL_ON = 7'h00;
  localparam logic [4:0] BRIGHT_MAX = 5'd16;

  // Duty is in sixteenths, so anything above full scale saturates.
  function automatic logic [4:0] clamp_bright(input logic [31:0] value);
    return (value > 32'(BRIGHT_MAX)) ? BRIGHT_MAX : value[4:0];
  endfunction

endpackage

// File: rtl/hex_segment_fx_if.sv
// Avalon-MM configuration port of one hex digit effect stage.
interface hex_segment_fx_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/hex_segment_fx_timer.sv
// PWM prescaler/step counter and blink half-period counter for one digit.
module hex_fx_timer #(
  parameter int BLINK_W = 26,
  parameter int PWM_DIV = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [4:0]         bright,
  input  logic [BLINK_W-1:0] blink_div,
  input  logic               blink_en,
  input  logic               blink_clr,
  output logic               pwm_on,
  output logic               blink_phase
);

  localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  logic [PRE_W-1:0]   prescaler;
  logic [3:0]         pwm_cnt;
  logic               pre_wrap;
  logic [BLINK_W-1:0] blink_cnt;
  logic [BLINK_W-1:0] div_eff;
  logic               blink_wrap;

  assign pre_wrap = (prescaler == PRE_W'(PWM_DIV - 1));
  assign pwm_on   = ({1'b0, pwm_cnt} < bright);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
    end else if (pre_wrap) begin
      prescaler <= '0;
      pwm_cnt   <= pwm_cnt + 4'd1;
    end else begin
      prescaler <= prescaler + PRE_W'(1);
    end
  end

  // A half-period of zero would never wrap, so it is treated as one cycle.
  assign div_eff    = (blink_div == '0) ? BLINK_W'(1) : blink_div;
  assign blink_wrap = (blink_cnt == div_eff - BLINK_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!blink_en || blink_clr) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_wrap) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + BLINK_W'(1);
    end
  end

endmodule

// File: rtl/hex_segment_fx.sv
// Per-digit 7-segment output stage: blink, PWM dimming, blanking and lamp test
// applied to the PIO pattern, configured through a small Avalon-MM slave.
module hex_segment_fx
  import hex_fx_pkg::*;
#(
  parameter int BLINK_W       = 26,
  parameter int BLINK_DEFAULT = 25_000_000,
  parameter int PWM_DIV       = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  hex_segment_fx_if.slave   bus,
  input  logic [6:0]        seg_in,
  output logic [6:0]        hex_n
);

  logic [2:0]         ctrl;
  logic [BLINK_W-1:0] blink_div;
  logic [4:0]         bright;
  logic               wr_en;
  logic               ctrl_wr;
  logic               div_wr;
  logic               blink_clr;
  logic               pwm_on;
  logic               blink_phase;
  logic [6:0]         hex_next;

  assign wr_en   = bus.chipselect & ~bus.write_n;
  assign ctrl_wr = wr_en && (bus.address == REG_CTRL);
  assign div_wr  = wr_en && (bus.address == REG_BLINK_DIV);

  // Turning blink off restarts the blink timer on the write edge itself.
  assign blink_clr = div_wr | (ctrl_wr & ~bus.writedata[CTRL_BLINK]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl      <= '0;
      blink_div <= BLINK_W'(BLINK_DEFAULT);
      bright    <= BRIGHT_MAX;
    end else if (wr_en) begin
      case (bus.address)
        REG_CTRL:      ctrl      <= bus.writedata[2:0];
        REG_BLINK_DIV: blink_div <= bus.writedata[BLINK_W-1:0];
        REG_BRIGHT:    bright    <= clamp_bright(bus.writedata);
        default:       ;
      endcase
    end
  end

  hex_fx_timer #(
    .BLINK_W (BLINK_W),
    .PWM_DIV (PWM_DIV)
  ) u_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .bright      (bright),
    .blink_div   (blink_div),
    .blink_en    (ctrl[CTRL_BLINK]),
    .blink_clr   (blink_clr),
    .pwm_on      (pwm_on),
    .blink_phase (blink_phase)
  );

  always_comb begin
    bus.readdata = '0;
    case (reg_addr_e'(bus.address))
      REG_CTRL:      bus.readdata = {29'd0, ctrl};
      REG_BLINK_DIV: bus.readdata = 32'(blink_div);
      REG_BRIGHT:    bus.readdata = 32'(bright);
      REG_STATUS:    bus.readdata = {23'd0, hex_n, pwm_on, blink_phase};
      default:       bus.readdata = '0;
    endcase
  end

  always_comb begin
    hex_next = seg_in;
    if (ctrl[CTRL_LAMP])
      hex_next = SEG_ALL_ON;
    else if (ctrl[CTRL_BLANK])
      hex_next = SEG_OFF;
    else if (ctrl[CTRL_BLINK] && blink_phase)
      hex_next = SEG_OFF;
    else if (!pwm_on)
      hex_next = SEG_OFF;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      hex_n <= SEG_OFF;
    else
      hex_n <= hex_next;
  end

endmodule

// File: tb/tb_hex_segment_fx.sv
// Directed bench for hex_segment_fx with a cycle-count based reference model
// and literal checks of blink, PWM, lamp test, blanking and reset.
module tb_hex_segment_fx;

  localparam int BLINK_W       = 26;
  localparam int BLINK_DEFAULT = 4;
  localparam int PWM_DIV       = 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [6:0] seg_in = 7'h40;
  logic [6:0] hex_n;

  hex_segment_fx_if bus ();

  int total = 0;
  int bad   = 0;

  hex_segment_fx #(
    .BLINK_W       (BLINK_W),
    .BLINK_DEFAULT (BLINK_DEFAULT),
    .PWM_DIV       (PWM_DIV)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .seg_in  (seg_in),
    .hex_n   (hex_n)
  );

  initial forever #10 clk = ~clk;

  // Model state: timers are derived from edge counts rather than counters.
  int         m_edges  = 0;
  int         m_age    = 0;
  int         m_div    = BLINK_DEFAULT;
  int         m_bright = 16;
  logic [2:0] m_ctrl   = 3'd0;
  logic [6:0] m_hex    = 7'h7F;
  logic       m_wr;
  logic       m_clear;

  function automatic int pwm_cnt_f();
    return (m_edges / PWM_DIV) % 16;
  endfunction

  function automatic logic pwm_on_f();
    return (pwm_cnt_f() < m_bright);
  endfunction

  function automatic logic phase_f();
    int div_eff;
    div_eff = (m_div == 0) ? 1 : m_div;
    return m_ctrl[0] ? (((m_age / div_eff) % 2) == 1) : 1'b0;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {29'd0, m_ctrl};
      2'd1:    return 32'(m_div);
      2'd2:    return 32'(m_bright);
      default: return {23'd0, m_hex, pwm_on_f(), phase_f()};
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_edges  = 0;
      m_age    = 0;
      m_div    = BLINK_DEFAULT;
      m_bright = 16;
      m_ctrl   = 3'd0;
      m_hex    = 7'h7F;
    end else begin
      m_wr = bus.chipselect && !bus.write_n;
      if (m_ctrl[1])                  m_hex = 7'h00;
      else if (m_ctrl[2])             m_hex = 7'h7F;
      else if (phase_f())             m_hex = 7'h7F;
      else if (!pwm_on_f())           m_hex = 7'h7F;
      else                            m_hex = seg_in;
      m_clear = !m_ctrl[0] || (m_wr && bus.address == 2'd1) ||
                (m_wr && bus.address == 2'd0 && !bus.writedata[0]);
      m_age   = m_clear ? 0 : m_age + 1;
      m_edges = m_edges + 1;
      if (m_wr) begin
        case (bus.address)
          2'd0: m_ctrl   = bus.writedata[2:0];
          2'd1: m_div    = int'(bus.writedata[BLINK_W-1:0]);
          2'd2: m_bright = (bus.writedata > 32'd16) ? 16 : int'(bus.writedata[4:0]);
          default: ;
        endcase
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("model_hex_n", 32'(hex_n), 32'(m_hex));
    checkOutput("model_readdata", bus.readdata, model_read(bus.address));
  end

  task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #2;
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk); #2;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic countHex(input logic [6:0] pattern, input int cycles, output int hits);
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (hex_n === pattern) hits++;
    end
  endtask

  int hits;

  initial begin
    bus.address    = 2'd0;
    bus.writedata  = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    #1 reset_n = 1'b0;

    $display("[TB] reset and release");
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_hex_off", 32'(hex_n), 32'h7F);
    reset_n = 1'b1;
    @(posedge clk); #2;
    checkOutput("first_seg_in", 32'(hex_n), 32'h40);
    bus.address = 2'd2;
    #1;
    checkOutput("bright_reset", bus.readdata, 32'd16);

    $display("[TB] blink with half-period 4");
    applyStimulus(2'd0, 32'd1);
    bus.address = 2'd3;
    @(negedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checkOutput("blink_hex", 32'(hex_n), (k <= 4) ? 32'h40 : 32'h7F);
      checkOutput("blink_phase", 32'(bus.readdata[0]), 32'((k / 4) % 2));
    end

    $display("[TB] pwm dimming");
    applyStimulus(2'd0, 32'd0);
    applyStimulus(2'd2, 32'd4);
    @(negedge clk);
    countHex(7'h40, 16, hits);
    checkOutput("pwm4_on_count", 32'(hits), 32'd4);
    applyStimulus(2'd2, 32'd0);
    @(negedge clk);
    countHex(7'h7F, 16, hits);
    checkOutput("pwm0_off_count", 32'(hits), 32'd16);

    $display("[TB] lamp test and blank");
    applyStimulus(2'd2, 32'd16);
    applyStimulus(2'd0, 32'd7);
    @(negedge clk);
    countHex(7'h00, 12, hits);
    checkOutput("lamp_on_count", 32'(hits), 32'd12);
    applyStimulus(2'd0, 32'd4);
    @(negedge clk);
    countHex(7'h7F, 12, hits);
    checkOutput("blank_off_count", 32'(hits), 32'd12);

    $display("[TB] bright clamp and zero half-period");
    applyStimulus(2'd2, 32'd31);
    bus.address = 2'd2;
    #1;
    checkOutput("bright_clamp", bus.readdata, 32'd16);
    seg_in = 7'h12;
    applyStimulus(2'd0, 32'd1);
    applyStimulus(2'd1, 32'd0);
    bus.address = 2'd3;
    @(negedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checkOutput("fast_phase", 32'(bus.readdata[0]), 32'(k % 2));
    end

    $display("[TB] reset mid-blink");
    seg_in = 7'h24;
    applyStimulus(2'd2, 32'd4);
    applyStimulus(2'd1, 32'd4);
    repeat (10) @(posedge clk);
    @(negedge clk); #1;
    reset_n = 1'b0;
    bus.address = 2'd0;
    #1;
    checkOutput("async_hex_off", 32'(hex_n), 32'h7F);
    checkOutput("ctrl_reset", bus.readdata, 32'd0);
    bus.address = 2'd1;
    #1;
    checkOutput("div_reset", bus.readdata, 32'd4);
    bus.address = 2'd2;
    #1;
    checkOutput("bright_reset2", bus.readdata, 32'd16);
    bus.address = 2'd3;
    #1;
    checkOutput("status_reset", bus.readdata, 32'h1FE);
    @(posedge clk); #2;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #2;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
